// File: rtl/tmr_health_monitor.sv
// Health monitor for a TMR voter: flags persistently disagreeing channels, counts
// mismatches, cross-checks the voter output and drives a steady/blinking health LED.
module tmr_health_monitor #(
    parameter int unsigned THRESH    = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned VOTER_LAT = 1,
    parameter int unsigned BLINK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             voted,
    input  logic             clr,
    output logic             fault_a,
    output logic             fault_b,
    output logic             fault_c,
    output logic [CNT_W-1:0] err_cnt_a,
    output logic [CNT_W-1:0] err_cnt_b,
    output logic [CNT_W-1:0] err_cnt_c,
    output logic             voter_err,
    output logic             led
);
    localparam int unsigned RUN_W = 8;
    localparam int unsigned WU_W  = 4;
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(THRESH);
    localparam logic [RUN_W-1:0] RUN_HIT   = RUN_W'(THRESH - 1);
    localparam logic [WU_W-1:0]  WU_DONE   = WU_W'(VOTER_LAT + 1);
    localparam logic [BLK_W-1:0] HALF_SLOW = BLK_W'(BLINK_DIV - 1);
    localparam logic [BLK_W-1:0] HALF_FAST = BLK_W'(BLINK_DIV / 4 - 1);
    localparam logic [2:0]       TAP       = 3'(VOTER_LAT - 1);

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_FAILED   = 2'd2
    } state_e;

    logic [2:0]       samp_q, samp_d;
    logic [RUN_W-1:0] run_q [3];
    logic [RUN_W-1:0] run_d [3];
    logic [CNT_W-1:0] err_q [3];
    logic [CNT_W-1:0] err_d [3];
    logic [2:0]       fault_q, fault_d;
    logic [6:0]       dly_q, dly_d;
    logic [WU_W-1:0]  wu_q, wu_d;
    logic             verr_q, verr_d;
    state_e           state_q, state_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             led_q, led_d;

    logic             maj, maj_d, two_plus;
    logic [2:0]       mis;
    logic [7:0]       taps;
    logic [BLK_W-1:0] half;

    // Sampling, majority, run/error counters, voter cross-check
    always_comb begin
        samp_d  = {c, b, a};
        maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
        mis     = samp_q ^ {3{maj}};
        taps    = {dly_q, maj};
        maj_d   = taps[TAP];
        dly_d   = {dly_q[5:0], maj};
        wu_d    = (wu_q == WU_DONE) ? wu_q : wu_q + WU_W'(1);
        verr_d  = verr_q | ((wu_q == WU_DONE) & (voted != maj_d));
        fault_d = fault_q;
        for (int i = 0; i < 3; i++) begin
            run_d[i] = '0;
            err_d[i] = err_q[i];
            if (mis[i]) begin
                run_d[i] = (run_q[i] == RUN_MAX) ? run_q[i] : run_q[i] + RUN_W'(1);
                if (run_q[i] == RUN_HIT) fault_d[i] = 1'b1;
                if (err_q[i] != '1) err_d[i] = err_q[i] + CNT_W'(1);
            end
        end
        // clr wins over any set or increment in the same cycle
        if (clr) begin
            fault_d = '0;
            dly_d   = '0;
            wu_d    = '0;
            verr_d  = 1'b0;
            for (int i = 0; i < 3; i++) begin
                run_d[i] = '0;
                err_d[i] = '0;
            end
        end
    end

    // Status FSM next state and LED blink generator
    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        led_d    = led_q;
        two_plus = (fault_q[0] & fault_q[1]) | (fault_q[0] & fault_q[2]) | (fault_q[1] & fault_q[2]);
        half     = (state_q == ST_FAILED) ? HALF_FAST : HALF_SLOW;
        if (clr) begin
            state_d = ST_OK;
        end else if (state_q != ST_FAILED) begin
            if (verr_q || two_plus) state_d = ST_FAILED;
            else if (|fault_q)      state_d = ST_DEGRADED;
            else                    state_d = ST_OK;
        end
        // Every state entry restarts the half-period with the LED lit
        if (state_d == ST_OK || state_d != state_q) begin
            blk_d = '0;
            led_d = 1'b1;
        end else if (blk_q == half) begin
            blk_d = '0;
            led_d = ~led_q;
        end else begin
            blk_d = blk_q + BLK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q  <= '0;
            fault_q <= '0;
            dly_q   <= '0;
            wu_q    <= '0;
            verr_q  <= 1'b0;
            state_q <= ST_OK;
            blk_q   <= '0;
            led_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                run_q[i] <= '0;
                err_q[i] <= '0;
            end
        end else begin
            samp_q  <= samp_d;
            fault_q <= fault_d;
            dly_q   <= dly_d;
            wu_q    <= wu_d;
            verr_q  <= verr_d;
            state_q <= state_d;
            blk_q   <= blk_d;
            led_q   <= led_d;
            for (int i = 0; i < 3; i++) begin
                run_q[i] <= run_d[i];
                err_q[i] <= err_d[i];
            end
        end
    end

    assign fault_a   = fault_q[0];
    assign fault_b   = fault_q[1];
    assign fault_c   = fault_q[2];
    assign err_cnt_a = err_q[0];
    assign err_cnt_b = err_q[1];
    assign err_cnt_c = err_q[2];
    assign voter_err = verr_q;
    assign led       = led_q;

endmodule

// File: tb/tb_tmr_health_monitor.sv
// Directed bench for tmr_health_monitor: vector table for a single-channel fault,
// hand-written sequences for runs, saturation, escalation, clr, voter check and reset.
module tb_tmr_health_monitor;
    localparam int unsigned CNT_W = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             a = 1'b0, b = 1'b0, c = 1'b0, clr = 1'b0, vflip = 1'b0;
    logic             voted, voter_q;
    logic             fault_a, fault_b, fault_c, voter_err, led;
    logic [CNT_W-1:0] err_cnt_a, err_cnt_b, err_cnt_c;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       a;
        logic       b;
        logic       c;
        logic       clr;
        logic [2:0] flt;
        logic [3:0] ea;
        logic       verr;
        logic       led;
    } vec_t;

    vec_t tbl [24];

    tmr_health_monitor #(
        .THRESH   (4),
        .CNT_W    (CNT_W),
        .VOTER_LAT(1),
        .BLINK_DIV(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c        (c),
        .voted    (voted),
        .clr      (clr),
        .fault_a  (fault_a),
        .fault_b  (fault_b),
        .fault_c  (fault_c),
        .err_cnt_a(err_cnt_a),
        .err_cnt_b(err_cnt_b),
        .err_cnt_c(err_cnt_c),
        .voter_err(voter_err),
        .led      (led)
    );

    always #5 clk = ~clk;

    // One-cycle voter model; vflip corrupts its output on demand
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) voter_q <= 1'b0;
        else        voter_q <= (a & b) | (a & c) | (b & c);
    end
    assign voted = voter_q ^ vflip;

    function automatic logic [16:0] obs();
        return {fault_c, fault_b, fault_a, err_cnt_c, err_cnt_b, err_cnt_a, voter_err, led};
    endfunction

    function automatic vec_t mk(input logic ia, input logic [2:0] flt, input logic [3:0] ea,
                                input logic eled);
        vec_t v;
        v.a = ia; v.b = 1'b0; v.c = 1'b0; v.clr = 1'b0;
        v.flt = flt; v.ea = ea; v.verr = 1'b0; v.led = eled;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic ia, input logic ib, input logic ic, input logic iclr,
                       input logic ivf);
        a = ia; b = ib; c = ic; clr = iclr; vflip = ivf;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Vector k: inputs sampled at edge k, outputs expected after edge k
        tbl[0]  = mk(1'b0, 3'b000, 4'd0, 1'b1);
        tbl[1]  = mk(1'b0, 3'b000, 4'd0, 1'b1);
        tbl[2]  = mk(1'b1, 3'b000, 4'd0, 1'b1);
        tbl[3]  = mk(1'b1, 3'b000, 4'd1, 1'b1);
        tbl[4]  = mk(1'b1, 3'b000, 4'd2, 1'b1);
        tbl[5]  = mk(1'b1, 3'b000, 4'd3, 1'b1);
        tbl[6]  = mk(1'b0, 3'b001, 4'd4, 1'b1);
        tbl[7]  = mk(1'b0, 3'b001, 4'd4, 1'b1);
        tbl[8]  = mk(1'b0, 3'b001, 4'd4, 1'b1);
        tbl[9]  = mk(1'b0, 3'b001, 4'd4, 1'b1);
        tbl[10] = mk(1'b0, 3'b001, 4'd4, 1'b1);
        tbl[11] = mk(1'b0, 3'b001, 4'd4, 1'b1);
        tbl[12] = mk(1'b0, 3'b001, 4'd4, 1'b1);
        tbl[13] = mk(1'b0, 3'b001, 4'd4, 1'b1);
        tbl[14] = mk(1'b0, 3'b001, 4'd4, 1'b1);
        tbl[15] = mk(1'b0, 3'b001, 4'd4, 1'b0);
        tbl[16] = mk(1'b0, 3'b001, 4'd4, 1'b0);
        tbl[17] = mk(1'b0, 3'b001, 4'd4, 1'b0);
        tbl[18] = mk(1'b0, 3'b001, 4'd4, 1'b0);
        tbl[19] = mk(1'b0, 3'b001, 4'd4, 1'b0);
        tbl[20] = mk(1'b0, 3'b001, 4'd4, 1'b0);
        tbl[21] = mk(1'b0, 3'b001, 4'd4, 1'b0);
        tbl[22] = mk(1'b0, 3'b001, 4'd4, 1'b0);
        tbl[23] = mk(1'b0, 3'b001, 4'd4, 1'b1);

        // Reset values
        repeat (2) @(posedge clk);
        #1 chk("reset", 32'(obs()), 32'd0);
        #2 rst_n = 1'b1;

        // Clean operation: all channels agree, toggling every 3 cycles
        for (int k = 1; k <= 12; k++) begin
            logic v;
            v = 1'(((k - 1) / 3) % 2);
            drv(v, v, v, 1'b0, 1'b0);
            step();
            chk($sformatf("clean%0d", k), 32'(obs()), 32'd1);
        end

        // Single-channel fault on a, table driven
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drv(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].clr, 1'b0);
            step();
            chk($sformatf("vec%0d", i + 1), 32'(obs()),
                32'({tbl[i].flt, 4'd0, 4'd0, tbl[i].ea, tbl[i].verr, tbl[i].led}));
        end

        // Interrupted runs: 3 bad, 1 good, 3 bad
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            drv((k <= 3) || (k >= 5 && k <= 7), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            chk($sformatf("intr_fault%0d", k), 32'(fault_a), 32'd0);
            if (k == 4)  chk("intr_cnt4", 32'(err_cnt_a), 32'd3);
            if (k == 12) chk("intr_end", 32'({err_cnt_a, led}), 32'({4'd6, 1'b1}));
        end

        // Counter saturation on b
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            drv(1'b0, k <= 20, 1'b0, 1'b0, 1'b0);
            step();
            if (k == 15) chk("sat14", 32'(err_cnt_b), 32'd14);
            if (k == 16) chk("sat15", 32'(err_cnt_b), 32'd15);
            if (k == 25) chk("sat_end", 32'(obs()), 32'({3'b010, 4'd0, 4'd15, 4'd0, 2'b00}) | 32'(led));
        end

        // Escalation a then c, fast blink, then clr together with a fresh mismatch
        do_reset();
        for (int k = 1; k <= 22; k++) begin
            drv(k <= 4, k == 17, (k >= 7 && k <= 10), k == 18, 1'b0);
            step();
            case (k)
                5:       chk("esc_fa", 32'(fault_a), 32'd1);
                11:      chk("esc_fac", 32'({fault_c, fault_b, fault_a}), 32'd5);
                12, 13:  chk($sformatf("esc_led%0d", k), 32'(led), 32'd1);
                14, 15:  chk($sformatf("esc_led%0d", k), 32'(led), 32'd0);
                16, 17:  chk($sformatf("esc_led%0d", k), 32'(led), 32'd1);
                18, 19, 20, 21, 22:
                         chk($sformatf("clr%0d", k), 32'(obs()), 32'd1);
                default: ;
            endcase
        end

        // Voter check: flip during warm-up is ignored, flip afterwards is sticky
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            drv(1'b1, 1'b1, 1'b1, 1'b0, (k == 2) || (k == 6));
            step();
            case (k)
                2, 3, 4, 5: chk($sformatf("vwarm%0d", k), 32'(voter_err), 32'd0);
                6:          chk("verr_set", 32'(voter_err), 32'd1);
                8, 11:      chk($sformatf("vled%0d", k), 32'({voter_err, led}), 32'd3);
                9:          chk("vled9", 32'({voter_err, led}), 32'd2);
                default: ;
            endcase
        end

        // Asynchronous reset off the clock edge
        #3 rst_n = 1'b0;
        #1 chk("async_rst", 32'(obs()), 32'd0);
        #2 rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
